ula_sequenciador_cmd: RTL and testbench

- Command sequencer for the 8-bit ULA datapath. It replaces key-stepped operand loading with a valid/ready command interface.
- Accepts a command {A, B, OP, chain}, drives the ULA operand/op inputs, and holds them for an op-dependent execution latency.
- Captures the result and flags, maintains the chaining accumulator and the sticky overflow, and returns a response under valid/ready backpressure.
- Sits between the board front-end (or a test host) and the combinational ULA core.

---
 rtl/ula_sequenciador_cmd.sv | 126 ++++++++++++
 tb/tb_ula_sequenciador_cmd.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/ula_sequenciador_cmd.sv
// ula_sequenciador_cmd: valid/ready command sequencer for the 8-bit ULA with chaining accumulator and sticky overflow.
// Define ULA_CMD_FIFO_EN to add a 2-entry command FIFO ahead of the FSM.
module ula_sequenciador_cmd #(
  parameter int WIDTH      = 8,
  parameter int MULDIV_LAT = 4,
  parameter int BASIC_LAT  = 1
) (
  input  logic             CLOCK_50,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [WIDTH-1:0] cmd_a,
  input  logic [WIDTH-1:0] cmd_b,
  input  logic [2:0]       cmd_op,
  input  logic             cmd_chain,
  input  logic             cmd_clear,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_op,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_ovf,
  input  logic             alu_zero,
  input  logic             alu_neg,
  input  logic             alu_err,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_result,
  output logic [3:0]       rsp_flags,
  output logic [WIDTH-1:0] acc,
  output logic             acc_valid,
  output logic             busy,
  output logic [1:0]       state_dbg
);
  localparam int CW = $clog2((MULDIV_LAT > BASIC_LAT ? MULDIV_LAT : BASIC_LAT) + 1);
  typedef enum logic [1:0] {IDLE = 2'b00, EXEC = 2'b01, RESP = 2'b10} state_t;
  state_t state;
  logic [WIDTH-1:0] a_r, b_r, in_a, in_b, a_sel;
  logic [2:0] op_r, in_op;
  logic [CW-1:0] cnt, lat;
  logic in_chain, take, ovf_sticky, ovf_new, kill;
`ifdef ULA_CMD_FIFO_EN
  logic [2*WIDTH+3:0] fq [2];
  logic [1:0] fcnt, widx;
  logic push;
  assign cmd_ready = !rst && fcnt != 2'd2;
  assign push = cmd_valid && cmd_ready;
  assign take = state == IDLE && fcnt != 2'd0;
  assign widx = fcnt - {1'b0, take};
  assign {in_a, in_b, in_op, in_chain} = fq[0];
  always_ff @(posedge CLOCK_50 or posedge rst)
    if (rst) begin
      fq[0] <= '0;
      fq[1] <= '0;
      fcnt <= 2'd0;
    end else begin
      if (take) fq[0] <= fq[1];
      if (push) fq[widx[0]] <= {cmd_a, cmd_b, cmd_op, cmd_chain};
      fcnt <= fcnt + {1'b0, push} - {1'b0, take};
    end
`else
  assign cmd_ready = !rst && state == IDLE;
  assign take = cmd_valid && cmd_ready;
  assign {in_a, in_b, in_op, in_chain} = {cmd_a, cmd_b, cmd_op, cmd_chain};
`endif
  // A clear on the accepting edge wins, so the command falls back to its own operand.
  assign a_sel = (in_chain && acc_valid && !cmd_clear) ? acc : in_a;
  assign lat = (in_op == 3'b101 || in_op == 3'b110) ? CW'(MULDIV_LAT) : CW'(BASIC_LAT);
  assign ovf_new = (ovf_sticky && !cmd_clear) || alu_ovf;
  assign alu_a = a_r;
  assign alu_b = b_r;
  assign alu_op = op_r;
  assign rsp_valid = state == RESP;
  assign busy = state != IDLE;
  assign state_dbg = state;
  always_ff @(posedge CLOCK_50 or posedge rst)
    if (rst) begin
      state <= IDLE;
      a_r <= '0;
      b_r <= '0;
      op_r <= 3'd0;
      cnt <= '0;
      kill <= 1'b0;
      rsp_result <= '0;
      rsp_flags <= 4'd0;
      acc <= '0;
      acc_valid <= 1'b0;
      ovf_sticky <= 1'b0;
    end else begin
      if (cmd_clear) begin
        acc <= '0;
        acc_valid <= 1'b0;
        ovf_sticky <= 1'b0;
      end
      case (state)
        IDLE: if (take) begin
          a_r <= a_sel;
          b_r <= in_b;
          op_r <= in_op;
          cnt <= lat;
          kill <= 1'b0;
          state <= EXEC;
        end
        EXEC: if (cnt == CW'(1)) begin
          rsp_result <= alu_err ? '0 : alu_result;
          rsp_flags <= {alu_err, alu_neg && !alu_err, ovf_new, alu_zero && !alu_err};
          ovf_sticky <= ovf_new;
          // A clear seen during execution kills the accumulator update of this response.
          if (!alu_err && !kill && !cmd_clear) begin
            acc <= alu_result;
            acc_valid <= 1'b1;
          end
          state <= RESP;
        end else begin
          cnt <= cnt - CW'(1);
          if (cmd_clear) kill <= 1'b1;
        end
        RESP: if (rsp_ready) begin
          a_r <= '0;
          b_r <= '0;
          op_r <= 3'd0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_ula_sequenciador_cmd.sv
// tb_ula_sequenciador_cmd: directed self-checking bench for ula_sequenciador_cmd (default build) with a behavioural ULA.
module tb_ula_sequenciador_cmd;
  logic CLOCK_50 = 1'b0;
  logic rst = 1'b1;
  logic cmd_valid = 1'b0, cmd_chain = 1'b0, cmd_clear = 1'b0, rsp_ready = 1'b1;
  logic [7:0] cmd_a = 8'd0, cmd_b = 8'd0;
  logic [2:0] cmd_op = 3'd0;
  logic cmd_ready, rsp_valid, acc_valid, busy;
  logic [7:0] alu_a, alu_b, alu_result, rsp_result, acc;
  logic [2:0] alu_op;
  logic alu_ovf, alu_zero, alu_neg, alu_err;
  logic [3:0] rsp_flags;
  logic [1:0] state_dbg;
  logic [8:0] s;
  logic [15:0] p;
  int n_checks = 0, n_fail = 0;

  always #5 CLOCK_50 = ~CLOCK_50;

  ula_sequenciador_cmd dut (
    .CLOCK_50(CLOCK_50), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op), .cmd_chain(cmd_chain), .cmd_clear(cmd_clear),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_result(alu_result),
    .alu_ovf(alu_ovf), .alu_zero(alu_zero), .alu_neg(alu_neg), .alu_err(alu_err),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result), .rsp_flags(rsp_flags),
    .acc(acc), .acc_valid(acc_valid), .busy(busy), .state_dbg(state_dbg)
  );

  // Behavioural ULA: add carries out as overflow, sub uses signed overflow, div by zero errors.
  always_comb begin
    s = 9'd0;
    p = 16'd0;
    alu_result = 8'd0;
    alu_ovf = 1'b0;
    alu_err = 1'b0;
    case (alu_op)
      3'd0: begin s = {1'b0, alu_a} + {1'b0, alu_b}; alu_result = s[7:0]; alu_ovf = s[8]; end
      3'd1: begin alu_result = alu_a - alu_b; alu_ovf = (alu_a[7] != alu_b[7]) && (alu_result[7] != alu_a[7]); end
      3'd2: alu_result = alu_a & alu_b;
      3'd3: alu_result = alu_a | alu_b;
      3'd4: alu_result = alu_a ^ alu_b;
      3'd5: begin p = alu_a * alu_b; alu_result = p[7:0]; alu_ovf = |p[15:8]; end
      3'd6: if (alu_b == 8'd0) begin alu_err = 1'b1; alu_result = 8'hFF; end else alu_result = alu_a / alu_b;
      default: alu_result = ~alu_a;
    endcase
    alu_zero = alu_result == 8'd0;
    alu_neg = alu_result[7];
  end

  task automatic tick;
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic issue(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op, input logic chain, input logic clr);
    cmd_a = a; cmd_b = b; cmd_op = op; cmd_chain = chain; cmd_clear = clr; cmd_valid = 1'b1;
    tick;
    cmd_valid = 1'b0; cmd_clear = 1'b0;
  endtask

  task automatic test_reset;
    tick;
    n_checks++; if ({cmd_ready, state_dbg, rsp_valid, busy, acc, acc_valid} !== 14'd0) begin n_fail++; $display("FAIL reset_state got %b exp 0", {cmd_ready, state_dbg, rsp_valid, busy, acc, acc_valid}); end
    rst = 1'b0;
    #1;
    n_checks++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL reset_release_ready got %b exp 1", cmd_ready); end
  endtask

  task automatic test_add;
    issue(8'd25, 8'd17, 3'd0, 1'b0, 1'b0);
    n_checks++; if ({state_dbg, rsp_valid, cmd_ready} !== 4'b0100) begin n_fail++; $display("FAIL add_exec got %b exp 0100", {state_dbg, rsp_valid, cmd_ready}); end
    tick;
    n_checks++; if ({rsp_valid, rsp_result, rsp_flags, acc, acc_valid} !== {1'b1, 8'h2A, 4'b0000, 8'h2A, 1'b1}) begin n_fail++; $display("FAIL add_rsp got %h/%h/%b acc %h/%b exp 2A/0000 acc 2A/1", rsp_valid, rsp_result, rsp_flags, acc, acc_valid); end
    tick;
    n_checks++; if ({state_dbg, alu_a, alu_b, alu_op} !== 21'd0) begin n_fail++; $display("FAIL add_idle got st %b alu %h %h %h exp all 0", state_dbg, alu_a, alu_b, alu_op); end
  endtask

  task automatic test_chain;
    issue(8'd0, 8'd50, 3'd1, 1'b1, 1'b0);
    n_checks++; if ({alu_a, alu_b, alu_op} !== {8'h2A, 8'd50, 3'd1}) begin n_fail++; $display("FAIL chain_alu_in got %h %h %h exp 2a 32 1", alu_a, alu_b, alu_op); end
    tick;
    n_checks++; if ({rsp_valid, rsp_result, rsp_flags, acc} !== {1'b1, 8'hF8, 4'b0100, 8'hF8}) begin n_fail++; $display("FAIL chain_rsp got %b %h %b acc %h exp 1 F8 0100 acc F8", rsp_valid, rsp_result, rsp_flags, acc); end
    tick;
  endtask

  task automatic test_div_err;
    issue(8'd9, 8'd0, 3'd6, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      n_checks++; if ({rsp_valid, alu_a, alu_b, alu_op} !== {1'b0, 8'd9, 8'd0, 3'd6}) begin n_fail++; $display("FAIL div_hold[%0d] got %b %h %h %h exp 0 09 00 6", i, rsp_valid, alu_a, alu_b, alu_op); end
      tick;
    end
    n_checks++; if ({rsp_valid, rsp_result, rsp_flags, acc, acc_valid} !== {1'b1, 8'h00, 4'b1000, 8'hF8, 1'b1}) begin n_fail++; $display("FAIL div_err_rsp got %b %h %b acc %h/%b exp 1 00 1000 acc F8/1", rsp_valid, rsp_result, rsp_flags, acc, acc_valid); end
    tick;
  endtask

  task automatic test_ovf_sticky;
    issue(8'd200, 8'd100, 3'd0, 1'b0, 1'b0);
    tick;
    n_checks++; if ({rsp_result, rsp_flags} !== {8'h2C, 4'b0010}) begin n_fail++; $display("FAIL ovf_set got %h %b exp 2C 0010", rsp_result, rsp_flags); end
    tick;
    issue(8'd1, 8'd1, 3'd0, 1'b0, 1'b0);
    tick;
    n_checks++; if ({rsp_result, rsp_flags} !== {8'h02, 4'b0010}) begin n_fail++; $display("FAIL ovf_sticky got %h %b exp 02 0010", rsp_result, rsp_flags); end
    tick;
    cmd_clear = 1'b1;
    tick;
    cmd_clear = 1'b0;
    n_checks++; if ({acc, acc_valid} !== 9'd0) begin n_fail++; $display("FAIL clear_acc got %h/%b exp 00/0", acc, acc_valid); end
    issue(8'd1, 8'd1, 3'd0, 1'b0, 1'b0);
    tick;
    n_checks++; if ({rsp_flags, acc, acc_valid} !== {4'b0000, 8'h02, 1'b1}) begin n_fail++; $display("FAIL ovf_cleared got %b acc %h/%b exp 0000 acc 02/1", rsp_flags, acc, acc_valid); end
    tick;
  endtask

  task automatic test_clear_accept;
    issue(8'd5, 8'd3, 3'd0, 1'b1, 1'b1);
    n_checks++; if (alu_a !== 8'd5) begin n_fail++; $display("FAIL clear_accept_a got %h exp 05", alu_a); end
    tick;
    n_checks++; if ({rsp_result, acc, acc_valid} !== {8'h08, 8'h08, 1'b1}) begin n_fail++; $display("FAIL clear_accept_rsp got %h acc %h/%b exp 08 acc 08/1", rsp_result, acc, acc_valid); end
    tick;
  endtask

  task automatic test_clear_inflight;
    issue(8'd7, 8'd7, 3'd5, 1'b0, 1'b0);
    cmd_clear = 1'b1;
    tick;
    cmd_clear = 1'b0;
    tick;
    tick;
    n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL mult_latency got %b exp 0", rsp_valid); end
    tick;
    n_checks++; if ({rsp_valid, rsp_result, rsp_flags, acc, acc_valid} !== {1'b1, 8'h31, 4'b0000, 8'h00, 1'b0}) begin n_fail++; $display("FAIL kill_rsp got %b %h %b acc %h/%b exp 1 31 0000 acc 00/0", rsp_valid, rsp_result, rsp_flags, acc, acc_valid); end
    tick;
  endtask

  task automatic test_backpressure;
    rsp_ready = 1'b0;
    issue(8'd3, 8'd4, 3'd0, 1'b0, 1'b0);
    tick;
    cmd_a = 8'd10; cmd_b = 8'd20; cmd_op = 3'd0; cmd_chain = 1'b0; cmd_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      n_checks++; if ({rsp_valid, rsp_result, rsp_flags, cmd_ready} !== {1'b1, 8'h07, 4'b0000, 1'b0}) begin n_fail++; $display("FAIL bp_hold[%0d] got %b %h %b rdy %b exp 1 07 0000 rdy 0", i, rsp_valid, rsp_result, rsp_flags, cmd_ready); end
      tick;
    end
    rsp_ready = 1'b1;
    tick;
    n_checks++; if ({state_dbg, rsp_valid, cmd_ready} !== 4'b0001) begin n_fail++; $display("FAIL bp_release got %b exp 0001", {state_dbg, rsp_valid, cmd_ready}); end
    tick;
    cmd_valid = 1'b0;
    n_checks++; if (state_dbg !== 2'b01) begin n_fail++; $display("FAIL bp_next_accept got %b exp 01", state_dbg); end
    tick;
    n_checks++; if ({rsp_valid, rsp_result, acc} !== {1'b1, 8'h1E, 8'h1E}) begin n_fail++; $display("FAIL bp_next_rsp got %b %h acc %h exp 1 1E acc 1E", rsp_valid, rsp_result, acc); end
    tick;
  endtask

  task automatic test_reset_exec;
    int seen;
    issue(8'd3, 8'd3, 3'd5, 1'b0, 1'b0);
    tick;
    rst = 1'b1;
    tick;
    n_checks++; if ({state_dbg, rsp_valid, acc, acc_valid, alu_a, alu_b, alu_op, cmd_ready} !== 32'd0) begin n_fail++; $display("FAIL reset_exec got st %b v %b acc %h/%b alu %h %h %h rdy %b exp all 0", state_dbg, rsp_valid, acc, acc_valid, alu_a, alu_b, alu_op, cmd_ready); end
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      tick;
      if (rsp_valid) seen++;
    end
    n_checks++; if (seen !== 0) begin n_fail++; $display("FAIL reset_abort got %0d responses exp 0", seen); end
  endtask

  initial begin
    test_reset;
    test_add;
    test_chain;
    test_div_err;
    test_ovf_sticky;
    test_clear_accept;
    test_clear_inflight;
    test_backpressure;
    test_reset_exec;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
